// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline sequencer: register enables, bubbles/flushes, PC redirect, halt drain
// Combines load-use stalls, ID redirects, multi-cycle memory waits and halt into per-stage controls.
module pipeline_stall_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             redirect,
  input  logic             mem_access,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pc_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_DRAIN, S_HALTED} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [1:0]      drain_q, drain_d;
  logic            in_drain_q, in_drain_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic            mem_hit;
  logic            redir_taken;
  logic            stall_inc;

  assign mem_hit = mem_access && (MEM_LAT > 0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      wait_q     <= '0;
      drain_q    <= '0;
      in_drain_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      drain_q    <= drain_d;
      in_drain_q <= in_drain_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    drain_d    = drain_q;
    in_drain_d = in_drain_q;
    case (state_q)
      S_RUN: begin
        if (mem_hit) begin
          state_d    = S_MEM_WAIT;
          wait_d     = WAIT_INIT;
          in_drain_d = 1'b0;
        end else if (halt_req) begin
          state_d = S_DRAIN;
          drain_d = 2'd2;
        end
      end
      S_MEM_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else if (in_drain_q) begin
          // completion of a freeze taken during drain also counts as one drain step
          in_drain_d = 1'b0;
          drain_d    = drain_q - 2'd1;
          state_d    = (drain_q == 2'd1) ? S_HALTED : S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (mem_hit) begin
          state_d    = S_MEM_WAIT;
          wait_d     = WAIT_INIT;
          in_drain_d = 1'b1;
        end else begin
          drain_d = drain_q - 2'd1;
          state_d = (drain_q == 2'd1) ? S_HALTED : S_DRAIN;
        end
      end
      default: state_d = S_HALTED;
    endcase
  end

  // stall and drain cycles share one output pattern: hold PC and IF/ID, bubble into ID/EX
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pc_sel      = 1'b0;
    halted      = 1'b0;
    redir_taken = 1'b0;
    if (!rst_n) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          if (mem_hit) begin
            pc_en = 1'b0;
          end else if (halt_req || stall_req) begin
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = 1'b1;
          end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            if (redirect) begin
              pc_sel      = 1'b1;
              ifid_flush  = 1'b1;
              redir_taken = 1'b1;
            end
          end
        end
        S_MEM_WAIT: begin
          if (wait_q == '0) begin
            if (in_drain_q) begin
              idex_en    = 1'b1;
              exmem_en   = 1'b1;
              memwb_en   = 1'b1;
              idex_flush = 1'b1;
            end else begin
              {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            end
          end
        end
        S_DRAIN: begin
          if (!mem_hit) begin
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = 1'b1;
          end
        end
        default: halted = 1'b1;
      endcase
    end
  end

  assign stall_inc = rst_n && (state_q != S_HALTED) && !pc_en;

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redir_taken && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - scoreboard bench for pipeline_stall_ctrl (MEM_LAT=2, CNT_W=4)
module tb_pipeline_stall_ctrl;

  localparam int LAT  = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n, stall_req, redirect, mem_access, halt_req, cnt_clr;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, pc_sel, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MEM_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .redirect(redirect),
    .mem_access(mem_access), .halt_req(halt_req), .cnt_clr(cnt_clr),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pc_sel(pc_sel), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // output vector order: pc, ifid, idex, exmem, memwb enables, ifid_flush, idex_flush, pc_sel, halted
  localparam logic [8:0] P_RESET  = 9'b00000_11_0_0;
  localparam logic [8:0] P_FROZEN = 9'b00000_00_0_0;
  localparam logic [8:0] P_BUBBLE = 9'b00111_01_0_0;
  localparam logic [8:0] P_FULL   = 9'b11111_00_0_0;
  localparam logic [8:0] P_REDIR  = 9'b11111_10_1_0;
  localparam logic [8:0] P_HALTED = 9'b00000_00_0_1;

  typedef struct {
    logic [8:0] o;
    int         sc;
    int         fc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err    = 0;
  bit done     = 0;

  // reference: pipeline activity described as remaining freeze/drain cycle budgets
  bit m_halted, m_draining, m_completing;
  int m_drain_left, m_freeze_left, m_sc, m_fc;

  task automatic model_reset();
    m_halted = 0; m_draining = 0; m_completing = 0;
    m_drain_left = 0; m_freeze_left = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic drain_step(output logic [8:0] o);
    o = P_BUBBLE;
    m_drain_left--;
    if (m_drain_left == 0) begin
      m_draining = 0;
      m_halted   = 1;
    end
  endtask

  task automatic step(input bit r, input bit st, input bit rd, input bit ma, input bit hr, input bit cc);
    exp_t e;
    logic [8:0] o;
    bit was_halted, fl;
    bit mem_now;
    @(posedge clk);
    #1;
    rst_n = r; stall_req = st; redirect = rd; mem_access = ma; halt_req = hr; cnt_clr = cc;
    e.sc = m_sc;
    e.fc = m_fc;
    if (!r) begin
      e.o = P_RESET;
      q.push_back(e);
      model_reset();
      return;
    end
    mem_now    = ma && (LAT > 0);
    was_halted = m_halted;
    fl = 0;
    if (m_halted) begin
      o = P_HALTED;
    end else if (m_freeze_left > 0) begin
      o = P_FROZEN;
      m_freeze_left--;
    end else if (m_completing) begin
      m_completing = 0;
      if (m_draining) drain_step(o);
      else o = P_FULL;
    end else if (mem_now) begin
      o = P_FROZEN;
      m_freeze_left = LAT - 1;
      m_completing  = 1;
    end else if (m_draining) begin
      drain_step(o);
    end else if (hr) begin
      o = P_BUBBLE;
      m_draining   = 1;
      m_drain_left = 2;
    end else if (st) begin
      o = P_BUBBLE;
    end else if (rd) begin
      o  = P_REDIR;
      fl = 1;
    end else begin
      o = P_FULL;
    end
    e.o = o;
    q.push_back(e);
    if (cc) begin
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (!was_halted && !o[8] && m_sc < CMAX) m_sc++;
      if (fl && m_fc < CMAX) m_fc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, pc_sel, halted};
        n_checks++;
        if (got !== e.o) begin
          n_err++;
          $display("FAIL outs at %0t: got %b want %b", $time, got, e.o);
        end
        n_checks++;
        if (int'(stall_cnt) != e.sc || $isunknown(stall_cnt)) begin
          n_err++;
          $display("FAIL stall_cnt at %0t: got %0d want %0d", $time, stall_cnt, e.sc);
        end
        n_checks++;
        if (int'(flush_cnt) != e.fc || $isunknown(flush_cnt)) begin
          n_err++;
          $display("FAIL flush_cnt at %0t: got %0d want %0d", $time, flush_cnt, e.fc);
        end
      end
    end
  end

  initial begin : driver
    bit r, st, rd, ma, hr, cc;
    rst_n = 0; stall_req = 1; redirect = 1; mem_access = 1; halt_req = 1; cnt_clr = 1;
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 1);
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
    idle(2);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0);
    idle(8);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 39) != 0);
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 2) == 0);
      ma = ($urandom_range(0, 4) == 0);
      hr = ($urandom_range(0, 59) == 0);
      cc = ($urandom_range(0, 29) == 0);
      step(r, st, rd, ma, hr, cc);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central sequencer for the 5-stage pipeline. It combines the forwarding unit's load-use stall request, ID-stage branch/jump redirects, multi-cycle data-memory waits and a halt request. From these it drives per-stage register enables, bubble/flush controls and the PC redirect select. It sits beside the forwarding/hazard logic and owns every pipeline-register enable in the datapath. Saturating stall/flush counters are included for performance debug.

Parameters:
MEM_LAT, 2, data-memory wait cycles per LW/SW in EX/MEM (0 = single-cycle memory, no waits)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
stall_req  input  1  load-use stall request from forwarding unit (valid in RUN)
redirect  input  1  ID stage resolved taken BGT / JUMP / JR (calc_branch qualified)
mem_access  input  1  instruction in EX/MEM is LW or SW
halt_req  input  1  request to drain and halt the pipeline
cnt_clr  input  1  clear performance counters
pc_en  output  1  PC register enable
ifid_en  output  1  IF/ID register enable
idex_en  output  1  ID/EX register enable
exmem_en  output  1  EX/MEM register enable
memwb_en  output  1  MEM/WB register enable
ifid_flush  output  1  load NOP into IF/ID on next edge
idex_flush  output  1  load NOP (bubble) into ID/EX on next edge
pc_sel  output  1  1 = PC loads redirect target
halted  output  1  pipeline drained and stopped
stall_cnt  output  CNT_W  cycles with pc_en=0 (excluding HALTED)
flush_cnt  output  CNT_W  redirects taken

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. State is registered; enable/flush outputs are combinational from state and inputs.
- While rst_n=0: all *_en=0, ifid_flush=idex_flush=1, pc_sel=0, halted=0. At the first edge with rst_n=0, state<=RUN, wait_cnt<=0, drain_cnt<=0, counters<=0. Reset asserted mid-wait or mid-drain aborts it with no residual effect.
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Per-cycle priority in RUN: mem wait > halt > load-use stall > redirect > normal.
- RUN, mem_access=1 and MEM_LAT>0:
  - All *_en=0 this cycle, no flushes.
  - Next state MEM_WAIT with wait_cnt<=MEM_LAT-1.
- MEM_WAIT:
  - wait_cnt>0: all *_en=0, wait_cnt decrements.
  - wait_cnt==0: all *_en=1, state<=RUN (access completes).
  - Total freeze is exactly MEM_LAT cycles per memory instruction.
  - stall_req, redirect and halt_req are ignored in this state. They are re-evaluated in RUN because the IF/ID and ID/EX contents are held.
- RUN, halt_req=1:
  - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
  - Next state DRAIN with drain_cnt<=2.
- DRAIN:
  - Same outputs as the RUN halt cycle, except that a mem_access suspends DRAIN using the same MEM_WAIT-style freeze. This is tracked by wait_cnt; drain_cnt holds during the freeze.
  - Otherwise drain_cnt decrements; at 0 the next state is HALTED.
- HALTED: all *_en=0, halted=1. Only reset exits.
- RUN, stall_req=1 (no mem/halt):
  - pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1.
  - redirect is ignored this cycle; the branch remains in IF/ID and re-resolves.
- RUN, redirect=1 (no stall):
  - All *_en=1, pc_sel=1, ifid_flush=1 (squash one wrong-path fetch).
  - flush_cnt increments.
- RUN, no events: all *_en=1, flushes 0, pc_sel=0.
- Counters:
  - stall_cnt increments on every cycle in RUN/MEM_WAIT/DRAIN with pc_en=0.
  - Both counters saturate at all-ones and do not wrap.
  - cnt_clr zeroes both counters. If cnt_clr coincides with an increment, clear wins.
- Flush and enable always coincide: flush forces a NOP into the enabled register, and no flush is ever asserted with that register's enable low, except in the reset state.
- MEM_LAT=0: mem_access is ignored and MEM_WAIT is unreachable.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all inputs=1, then release with inputs=0 -> during reset all enables 0 and flushes 1; first RUN cycle all *_en=1, stall_cnt=flush_cnt=0.
- MEM_LAT=2, single-cycle mem_access pulse held until enables return -> exactly 2 cycles all *_en=0, then 1 cycle all *_en=1, stall_cnt=2.
- stall_req and redirect both high for 1 cycle, then redirect alone -> cycle 1: pc_en=0, idex_flush=1, pc_sel=0; cycle 2: pc_sel=1, ifid_flush=1; flush_cnt=1.
- mem_access with redirect during MEM_WAIT -> redirect has no effect until RUN; pc_sel asserts the cycle after the freeze ends.
- halt_req pulse in RUN with MEM_LAT=2, and a mem_access during DRAIN -> halted rises after 3 drain cycles plus 2 freeze cycles; halted remains 1 until rst_n=0.
- CNT_W=4, 20 consecutive stall_req cycles, then cnt_clr together with a stall -> stall_cnt saturates at 15 and then reads 0 after the clear.
